// File: rtl/arb_prio_8_if.sv
// Request/grant bundle between the eight clients and the arbiter.
interface arb_prio_8_if;
   logic [7:0] req;
   logic       rr_mode;
   logic [7:0] gnt;
   logic [2:0] gnt_id;
   logic       gnt_valid;
   logic       preempt;

   // Client side: drives the requests and the mode, observes the grant.
   modport master (output req, rr_mode, input gnt, gnt_id, gnt_valid, preempt);
   // Arbiter side.
   modport slave  (input req, rr_mode, output gnt, gnt_id, gnt_valid, preempt);
endinterface

// File: rtl/arb_prio_8.sv
// 8-way arbiter: fixed (highest index wins) or round-robin selection,
// grant held until release or until the hold limit preempts the owner.
module arb_prio_8 #(
   parameter int unsigned MAX_HOLD = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   arb_prio_8_if.slave   bus
);

   localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD - 1);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t     state, state_nxt;
   logic [7:0] hold_cnt, hold_nxt;
   logic [2:0] rr_last, rr_last_nxt;
   logic [7:0] cand;
   logic [2:0] win;
   logic       load, pre;
   logic [7:0] gnt_nxt;
   logic [2:0] id_nxt;
   logic       valid_nxt;

   // Winner over candidate vector c. Fixed: highest set index.
   // RR: first set bit searching last-1, last-2, ... wrapping, ending at last.
   function automatic logic [2:0] pick(input logic [7:0] c, input logic rr,
                                       input logic [2:0] last);
      logic [2:0] idx;
      pick = '0;
      if (!rr) begin
         for (int i = 0; i < 8; i++)
            if (c[i]) pick = 3'(i);
      end else begin
         // walk the search order backwards so the earliest hit is written last
         for (int k = 8; k >= 1; k--) begin
            idx = last - 3'(k);
            if (c[idx]) pick = idx;
         end
      end
   endfunction

   // Candidates: every requester except the current owner while busy.
   always_comb begin
      cand = bus.req;
      if (state == BUSY) cand[bus.gnt_id] = 1'b0;
      win = pick(cand, bus.rr_mode, rr_last);
   end

   // State register plus the registered grant outputs and counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         hold_cnt      <= '0;
         rr_last       <= '0;
         bus.gnt       <= '0;
         bus.gnt_id    <= '0;
         bus.gnt_valid <= 1'b0;
         bus.preempt   <= 1'b0;
      end else begin
         state         <= state_nxt;
         hold_cnt      <= hold_nxt;
         rr_last       <= rr_last_nxt;
         bus.gnt       <= gnt_nxt;
         bus.gnt_id    <= id_nxt;
         bus.gnt_valid <= valid_nxt;
         bus.preempt   <= pre;
      end
   end

   // Next-state decision: release first, then hold-limit preempt, else hold.
   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      pre       = 1'b0;
      case (state)
         IDLE: begin
            if (|bus.req) begin
               load      = 1'b1;
               state_nxt = BUSY;
            end
         end
         BUSY: begin
            if (!bus.req[bus.gnt_id]) begin
               if (|cand) load = 1'b1;         // back-to-back handoff
               else       state_nxt = IDLE;
            end else if (hold_cnt == HOLD_LIM && |cand) begin
               load = 1'b1;
               pre  = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Next output values; gnt, gnt_id and gnt_valid always move together.
   always_comb begin
      gnt_nxt     = bus.gnt;
      id_nxt      = bus.gnt_id;
      valid_nxt   = bus.gnt_valid;
      rr_last_nxt = rr_last;
      hold_nxt    = hold_cnt;
      if (load) begin
         gnt_nxt     = 8'b1 << win;
         id_nxt      = win;
         valid_nxt   = 1'b1;
         rr_last_nxt = win;
         hold_nxt    = '0;
      end else if (state_nxt == IDLE) begin
         gnt_nxt   = '0;
         id_nxt    = '0;
         valid_nxt = 1'b0;
         hold_nxt  = '0;
      end else if (hold_cnt < HOLD_LIM) begin
         hold_nxt  = hold_cnt + 8'd1;          // saturates at the limit
      end
   end

endmodule

// File: tb/tb_arb_prio_8.sv
// Directed bench for arb_prio_8: a MAX_HOLD=4 instance covers priority,
// handoff, hold limit and mode switch; a MAX_HOLD=1 instance covers rotation.
module tb_arb_prio_8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   arb_prio_8_if a_if ();
   arb_prio_8_if b_if ();

   arb_prio_8 #(.MAX_HOLD(4)) dut_a (.clk(clk), .rst_n(rst_n), .bus(a_if));
   arb_prio_8 #(.MAX_HOLD(1)) dut_b (.clk(clk), .rst_n(rst_n), .bus(b_if));

   typedef struct {
      string      tag;
      bit         sel;
      logic [7:0] gnt;
      logic [2:0] id;
      logic       valid;
      logic       pre;
   } exp_t;

   exp_t sb[$];

   task automatic push(input string tag, input bit sel, input logic v,
                       input logic [2:0] id, input logic pre);
      exp_t e;
      e.tag   = tag;
      e.sel   = sel;
      e.valid = v;
      e.id    = v ? id : 3'd0;
      e.gnt   = v ? (8'b1 << id) : 8'h00;
      e.pre   = pre;
      sb.push_back(e);
   endtask

   task automatic cmp(input string tag, input string fld,
                      input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s.%s got=%h exp=%h", tag, fld, obs, exp);
      end
   endtask

   task automatic pop_check();
      exp_t e;
      if (sb.size() == 0) begin
         checks++;
         failures++;
         $error("FAIL scoreboard empty");
         return;
      end
      e = sb.pop_front();
      if (!e.sel) begin
         cmp(e.tag, "gnt",   a_if.gnt,             e.gnt);
         cmp(e.tag, "id",    8'(a_if.gnt_id),      8'(e.id));
         cmp(e.tag, "valid", 8'(a_if.gnt_valid),   8'(e.valid));
         cmp(e.tag, "pre",   8'(a_if.preempt),     8'(e.pre));
      end else begin
         cmp(e.tag, "gnt",   b_if.gnt,             e.gnt);
         cmp(e.tag, "id",    8'(b_if.gnt_id),      8'(e.id));
         cmp(e.tag, "valid", 8'(b_if.gnt_valid),   8'(e.valid));
         cmp(e.tag, "pre",   8'(b_if.preempt),     8'(e.pre));
      end
   endtask

   // Drive inputs, queue the expected result, sample 1 time unit after the edge.
   task automatic step(input string tag, input bit sel, input logic [7:0] r,
                       input logic rr, input logic v, input logic [2:0] id,
                       input logic pre);
      if (!sel) begin a_if.req = r; a_if.rr_mode = rr; end
      else      begin b_if.req = r; b_if.rr_mode = rr; end
      push(tag, sel, v, id, pre);
      @(posedge clk);
      #1;
      pop_check();
   endtask

   task automatic pulse_reset();
      #2 rst_n = 1'b0;
      @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      a_if.req = '0; a_if.rr_mode = 1'b0;
      b_if.req = '0; b_if.rr_mode = 1'b1;
      #1;
      push("rst_init", 0, 0, 0, 0); pop_check();
      @(posedge clk); #3 rst_n = 1'b1;
      @(posedge clk); #1;
      push("rst_idle", 0, 0, 0, 0); pop_check();

      // asynchronous reset in the middle of a grant
      step("rst_grant", 0, 8'h20, 0, 1, 5, 0);
      #2 rst_n = 1'b0; a_if.req = 8'h00;
      #1;
      push("rst_async", 0, 0, 0, 0); pop_check();
      @(posedge clk); #3 rst_n = 1'b1;
      step("rst_after", 0, 8'h00, 0, 0, 0, 0);

      // fixed priority
      step("fix_a", 0, 8'h24, 0, 1, 5, 0);
      step("fix_b", 0, 8'h04, 0, 1, 2, 0);
      step("fix_c", 0, 8'h00, 0, 0, 0, 0);

      // gapless handoff 4 -> 1
      step("ho_a", 0, 8'h10, 0, 1, 4, 0);
      step("ho_b", 0, 8'h12, 0, 1, 4, 0);
      step("ho_c", 0, 8'h02, 0, 1, 1, 0);
      step("ho_d", 0, 8'h00, 0, 0, 0, 0);

      // hold limit: owner 3 keeps 4 cycles, then 6 preempts
      step("hold_0", 0, 8'h08, 0, 1, 3, 0);
      step("hold_1", 0, 8'h48, 0, 1, 3, 0);
      step("hold_2", 0, 8'h48, 0, 1, 3, 0);
      step("hold_3", 0, 8'h48, 0, 1, 3, 0);
      step("hold_pre", 0, 8'h48, 0, 1, 6, 1);
      step("hold_after", 0, 8'h48, 0, 1, 6, 0);
      step("hold_idle", 0, 8'h00, 0, 0, 0, 0);

      // lone owner is never preempted; saturated counter preempts at once
      step("alone_0", 0, 8'h08, 0, 1, 3, 0);
      for (int i = 0; i < 20; i++) step("alone_n", 0, 8'h08, 0, 1, 3, 0);
      step("sat_pre", 0, 8'h48, 0, 1, 6, 1);
      step("sat_idle", 0, 8'h00, 0, 0, 0, 0);

      // round-robin from reset, each owner dropping its line for one cycle
      pulse_reset();
      step("rr_first", 0, 8'hFF, 1, 1, 7, 0);
      for (int i = 7; i >= 0; i--) begin
         logic [7:0] r;
         r = 8'hFF & ~(8'b1 << i);
         step("rr_rot", 0, r, 1, 1, 3'(i + 7), 0);
      end
      step("rr_idle", 0, 8'h00, 1, 0, 0, 0);

      // mode switch while 7 owns
      step("ms_own", 0, 8'h83, 0, 1, 7, 0);
      step("ms_hold", 0, 8'h83, 1, 1, 7, 0);
      step("ms_rr1", 0, 8'h03, 1, 1, 1, 0);
      step("ms_rr0", 0, 8'h81, 1, 1, 0, 0);
      step("ms_idle", 0, 8'h00, 1, 0, 0, 0);
      step("fx_own", 0, 8'h83, 0, 1, 7, 0);
      step("fx_1", 0, 8'h03, 0, 1, 1, 0);
      step("fx_7", 0, 8'h81, 0, 1, 7, 0);
      step("fx_idle", 0, 8'h00, 0, 0, 0, 0);

      // MAX_HOLD=1: per-cycle rotation with all lines held high
      pulse_reset();
      step("m1_first", 1, 8'hFF, 1, 1, 7, 0);
      for (int i = 6; i >= 0; i--) step("m1_rot", 1, 8'hFF, 1, 1, 3'(i), 1);
      step("m1_wrap", 1, 8'hFF, 1, 1, 7, 1);
      step("m1_idle", 1, 8'h00, 1, 0, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/arb_prio_8.md
# arb_prio_8

8-requester arbiter that shares a single downstream resource (bus, encoder datapath, register port) among eight clients. It selects one winner per arbitration using either fixed highest-index-wins priority or round-robin. The grant is held until the owner releases its request or a hold-time limit preempts it. It sits between the request lines of the clients and the select/enable input of the shared resource.

## Interface
- MAX_HOLD, 16, maximum consecutive cycles a grant is held while other requests are pending; legal range 1..255.
- clk  input  1  sole clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  8  request lines; bit i = client i. Level-sensitive; the client holds the line high while it uses the resource.
- rr_mode  input  1  0 = fixed priority (bit 7 highest, bit 0 lowest); 1 = round-robin.
- gnt  output  8  one-hot grant, or all zero when idle; registered.
- gnt_id  output  3  binary index of the granted client; 0 when idle; registered.
- gnt_valid  output  1  high while any grant is active; registered.
- preempt  output  1  one-cycle pulse on the edge a grant is forcibly removed by the hold limit; registered.

## Operation
- States:
  - IDLE: no owner.
  - BUSY: owner = gnt_id.
- Reset (asynchronous, immediate): state IDLE; gnt=0, gnt_id=0, gnt_valid=0, preempt=0, hold_cnt=0, rr_last=0.
- Winner function. It operates on a candidate vector C (req with the current owner's bit masked in BUSY).
  - Fixed mode: the highest set index of C wins.
  - RR mode: search from index rr_last-1 downward, wrapping 0->7, ending at rr_last; the first set bit wins.
  - rr_mode is sampled at every decision edge; a change affects only the next decision.
- IDLE transitions:
  - If req != 0, grant winner(req) on the next edge and go to BUSY with hold_cnt=0.
  - Otherwise stay in IDLE.
- BUSY, each edge, evaluated in this order:
  1. Release. If req[owner]==0: if C != 0, grant winner(C) on this edge (back-to-back handoff, no idle gap) with hold_cnt=0. Otherwise clear gnt and go to IDLE.
  2. Preempt. If req[owner]==1, hold_cnt==MAX_HOLD-1, and C != 0: grant winner(C), hold_cnt=0, and pulse preempt=1 for one cycle.
  3. Hold. Otherwise keep the grant. hold_cnt increments and saturates at MAX_HOLD-1; with no other requester, the owner keeps the grant indefinitely.
- rr_last is loaded with the new owner's index on every grant. It is updated in both modes.
- gnt, gnt_id and gnt_valid always change together. gnt is never multi-hot.
- The arbiter never grants a client whose req bit is low at the decision edge.
- MAX_HOLD=1: any pending competitor preempts the owner after one cycle, which gives per-cycle rotation.

## Timing
- Grant latency: 1 cycle. A req that goes high before edge n produces gnt visible after edge n.
- Release latency: 1 cycle. A req[owner] that drops before edge n means gnt changes after edge n.
- Maximum continuous ownership with competitors pending: MAX_HOLD cycles.
- preempt is high for exactly the cycle following the preempting edge. It is low in all other cycles.
- Asynchronous reset assertion mid-grant clears the outputs without waiting for clk. The first grant after deassertion is no earlier than the first clk edge at which rst_n is high.

## Test plan
- Reset: assert rst_n=0 mid-grant (gnt=8'h20) -> gnt=0, gnt_id=0, gnt_valid=0, preempt=0 immediately. After release with req=0, the outputs stay 0.
- Fixed priority, rr_mode=0: req=8'b0010_0100 -> after one edge, gnt=8'h20, gnt_id=5. Drop req[5] -> next edge gnt=8'h04, gnt_id=2. Drop req[2] -> next edge gnt=0, gnt_valid=0.
- Hold limit, MAX_HOLD=4, rr_mode=0: req[3] held high and granted, req[6] raised 1 cycle later -> client 3 keeps its grant for 4 cycles, then gnt=8'h40 and preempt=1 for one cycle. Alternatively, req[3] alone stays granted for 20 cycles with preempt=0.
- Round-robin, rr_mode=1: req=8'hFF from reset, each owner dropping req for one cycle on grant end, or MAX_HOLD=1 with the lines held high -> gnt_id sequence 7,6,5,4,3,2,1,0,7.
- Handoff with no gap: owner 4 drops req while req[1] is high -> gnt goes 8'h10 -> 8'h02 on a single edge and gnt_valid stays 1.
- Mode switch: set rr_mode 0->1 while client 7 owns the grant and req=8'h83; owner releases -> next grant is client 1 (RR from 6 downward). With rr_mode=0 it would be client 1 as well; then release 1 with req[7] high -> client 7 in fixed mode, client 0 in RR mode.
